in_port_fifo: RTL and testbench
===============================

# in_port_fifo

Buffered, parametrised input port for the Mini SRC CPU. It captures words from an external device through a valid/ready handshake into a DEPTH-entry FIFO. It presents the oldest word to the CPU bus multiplexer and exposes a status word for polling. It replaces the single-register input port when the external source can produce bursts faster than the CPU reads them.

## Interface
Parameters:
- DATA_WIDTH, 32: width of the external data word (1..32); zero-extended onto the 32-bit bus.
- DEPTH, 8: FIFO entries; power of two, 2..1024.
- CW, derived = log2(DEPTH)+1: occupancy count width.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- clear  in  1  reset, synchronous, active-high.
- InPortValid  in  1  external device offers InPortData this cycle.
- InPortData  in  DATA_WIDTH  external input word.
- InPortReady  out  1  FIFO can accept a word (= not full), registered state only.
- InPortRead  in  1  CPU consumed the head word (pulsed with the bus read); pops one entry.
- InStatusClr  in  1  clears the sticky overflow flag.
- BusMuxIn_InPort  out  32  head word, zero-extended; 32'b0 when empty.
- BusMuxIn_InStatus  out  32  status word: [CW-1:0] count, [16] empty, [17] full, [18] overflow, other bits 0.
- InPortAvail  out  1  FIFO non-empty (interrupt request / poll bit).
- InPortOverflow  out  1  sticky: a word was offered while full.

## Operation
- Storage: DEPTH x DATA_WIDTH array, write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (CW bits, 0..DEPTH).
- Push: InPortValid && !full at a clock edge → write InPortData at wptr, wptr+1, count+1.
- Drop: InPortValid && full → word discarded, overflow set to 1; pointers and count unchanged.
- Pop: InPortRead && !empty → rptr+1, count−1. InPortRead while empty is ignored (no underflow, no flag).
- Simultaneous push and pop:
  - Not empty and not full → both happen; count unchanged.
  - Empty → only the push happens; count becomes 1; the pop is ignored.
  - Full → the pop happens; the push is dropped and overflow is set. Acceptance is judged on start-of-cycle full.
- Overflow: set by any drop; cleared by InStatusClr. If set and clear happen in the same cycle, set wins.
- empty = (count==0); full = (count==DEPTH). InPortReady = !full. InPortAvail = !empty.
- BusMuxIn_InPort = empty ? 0 : zero-extend(mem[rptr]). This is combinational from registered state; it never depends on InPortRead in the same cycle.
- clear (synchronous) → pointers 0, count 0, overflow 0. Memory contents are not cleared, but outputs read as empty.

## Timing
- Reset values (cycle after clear sampled high):
  - BusMuxIn_InPort = 0
  - BusMuxIn_InStatus = 32'h0001_0000 (empty only)
  - InPortReady = 1
  - InPortAvail = 0
  - InPortOverflow = 0
- clear takes priority over push, pop and InStatusClr in the same cycle. Reset mid-burst discards all stored words.
- Latency: a word pushed at edge N appears on BusMuxIn_InPort (when the FIFO was empty) and in count immediately after edge N.
- Pop at edge N: the next head word is visible after edge N. The CPU samples the bus value before or in the same cycle it asserts InPortRead.
- Handshake: a transfer occurs on each edge where InPortValid && InPortReady. The source may hold InPortValid high for back-to-back words; one word per cycle maximum.
- Pointer wrap: wptr/rptr roll from DEPTH−1 to 0 with no bubble.
- Outputs are glitch-free functions of registers. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert clear 2 cycles with InPortValid=1 → status 32'h0001_0000, bus 0, InPortReady=1, nothing stored.
- Single word (DATA_WIDTH=8): push 8'hA5 → after edge, BusMuxIn_InPort=32'h0000_00A5, count=1, InPortAvail=1. Pop → bus 0, status empty.
- Fill and overflow (DEPTH=8): push 1..9 back-to-back → first 8 stored, InPortReady=0 after the 8th, word 9 dropped, status 32'h0006_0008. InStatusClr → 32'h0002_0008. Pop 8 → reads 1..8 in order.
- Wrap: push 5, pop 5, push 6, pop 6 → order preserved across the pointer wrap, count returns to 0.
- Simultaneous events:
  - Push+pop at count=3 → count stays 3, head advances.
  - Push+pop at empty → count 1.
  - Push+pop at full → count 7, overflow=1.
  - InStatusClr with a drop in the same cycle → overflow stays 1.
- Clear mid-operation: count=5, assert clear with InPortValid and InPortRead high → next cycle empty reset values; the following push of 32'hDEAD_BEEF reads back correctly.

Source files
------------

// File: rtl/in_port_fifo_if.sv
// ---------------------------------------------------------------------------
// in_port_fifo_if
//
// Bundles the external-device handshake and the CPU-side bus/status signals
// of the buffered input port so they travel as a single port.
//
// Parameters:
//   DATA_WIDTH - width of the external data word (1..32)
//
// Signals:
//   InPortValid       device -> fifo  word offered this cycle
//   InPortData        device -> fifo  the offered word
//   InPortReady       fifo -> device  fifo can take a word (not full)
//   InPortRead        cpu -> fifo     cpu consumed the head word, pop one
//   InStatusClr       cpu -> fifo     clear the sticky overflow flag
//   BusMuxIn_InPort   fifo -> cpu     head word, zero-extended, 0 when empty
//   BusMuxIn_InStatus fifo -> cpu     {overflow, full, empty, count} status
//   InPortAvail       fifo -> cpu     fifo non-empty
//   InPortOverflow    fifo -> cpu     sticky drop indicator
//
// Modports:
//   slave  - the fifo itself
//   master - the environment (device plus cpu) driving the fifo
// ---------------------------------------------------------------------------
interface in_port_fifo_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  InPortValid;
  logic [DATA_WIDTH-1:0] InPortData;
  logic                  InPortReady;
  logic                  InPortRead;
  logic                  InStatusClr;
  logic [31:0]           BusMuxIn_InPort;
  logic [31:0]           BusMuxIn_InStatus;
  logic                  InPortAvail;
  logic                  InPortOverflow;

  modport slave (
    input  InPortValid,
    input  InPortData,
    input  InPortRead,
    input  InStatusClr,
    output InPortReady,
    output BusMuxIn_InPort,
    output BusMuxIn_InStatus,
    output InPortAvail,
    output InPortOverflow
  );

  modport master (
    output InPortValid,
    output InPortData,
    output InPortRead,
    output InStatusClr,
    input  InPortReady,
    input  BusMuxIn_InPort,
    input  BusMuxIn_InStatus,
    input  InPortAvail,
    input  InPortOverflow
  );

endinterface

// File: rtl/in_port_fifo.sv
// ---------------------------------------------------------------------------
// in_port_fifo
//
// Buffered input port for the Mini SRC CPU. Words offered by an external
// device through a valid/ready handshake are queued in a DEPTH-entry FIFO.
// The oldest word is presented to the CPU bus multiplexer and a status word
// is exposed for polling. Words offered while the FIFO is full are dropped
// and recorded in a sticky overflow flag.
//
// Parameters:
//   DATA_WIDTH - external word width (1..32), zero-extended onto the bus
//   DEPTH      - number of entries, power of two (2..1024)
//
// Ports:
//   clock - system clock, all state changes on the rising edge
//   clear - synchronous active-high reset, beats every other request
//   port  - in_port_fifo_if.slave carrying handshake, bus and status
//
// Status word layout:
//   [CW-1:0] occupancy count, [16] empty, [17] full, [18] overflow
//
// Every output is derived from registered state only, so nothing the
// device or CPU drives in a cycle can ripple through to an output.
// ---------------------------------------------------------------------------
module in_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic           clock,
  input  logic           clear,
  in_port_fifo_if.slave  port
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

  // Storage and bookkeeping registers.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;

  // Occupancy decode and event qualification.
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // Output staging.
  logic [31:0] head_word;
  logic [31:0] status_word;

  // Acceptance is judged against the count at the start of the cycle, so a
  // pop in the same cycle never frees space for the word offered alongside
  // it when the FIFO is full, and a read of an empty FIFO never pops the
  // word being pushed in that cycle.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH_COUNT);
    push  = port.InPortValid && !full;
    drop  = port.InPortValid && full;
    pop   = port.InPortRead && !empty;
  end

  // Next-state for pointers, count and the sticky overflow flag. Pointers
  // are exactly log2(DEPTH) bits wide so wrapping is free. A drop sets the
  // flag even when the CPU clears it in the same cycle, so a lost word is
  // never silently forgotten.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (port.InStatusClr) begin
      overflow_d = 1'b0;
    end
  end

  // Control registers. clear wins over everything else in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Data array. It is never reset; the zeroed count hides stale contents.
  // Writes are suppressed during clear so a clear cycle stores nothing.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_q[wptr_q] <= port.InPortData;
    end
  end

  // Head word and status word, built from registered state. The head is
  // forced to zero when empty so stale memory never reaches the bus.
  always_comb begin
    head_word = '0;
    if (!empty) begin
      head_word[DATA_WIDTH-1:0] = mem_q[rptr_q];
    end

    status_word         = '0;
    status_word[CW-1:0] = count_q;
    status_word[16]     = empty;
    status_word[17]     = full;
    status_word[18]     = overflow_q;
  end

  assign port.BusMuxIn_InPort   = head_word;
  assign port.BusMuxIn_InStatus = status_word;
  assign port.InPortReady       = !full;
  assign port.InPortAvail       = !empty;
  assign port.InPortOverflow    = overflow_q;

endmodule

// File: tb/tb_in_port_fifo.sv
// ---------------------------------------------------------------------------
// tb_in_port_fifo
//
// Drives the buffered input port with directed scenarios followed by
// randomized traffic. A queue-based model of the FIFO predicts every
// output after each clock edge; predictions go into a scoreboard queue
// that an independent monitor drains on the falling edge.
// ---------------------------------------------------------------------------
module tb_in_port_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  in_port_fifo_if #(.DATA_WIDTH(DW)) bus_if ();

  in_port_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock (clock),
    .clear (clear),
    .port  (bus_if.slave)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] bus;
    logic [31:0] status;
    logic        ready;
    logic        avail;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[$];
  logic        model_ovf = 1'b0;
  int unsigned cyc_count = 0;
  int          checks    = 0;
  int          failures  = 0;

  // Counts rising edges so each prediction can name the edge it belongs to.
  always @(posedge clock) begin
    cyc_count <= cyc_count + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d",
               name, actual, expected, cyc_count);
    end
  endtask

  // Monitor: compares the DUT against every prediction whose edge has
  // already happened.
  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_count) begin
      e = exp_q.pop_front();
      check_output("bus",    bus_if.BusMuxIn_InPort,   e.bus);
      check_output("status", bus_if.BusMuxIn_InStatus, e.status);
      check_output("ready",  32'(bus_if.InPortReady),    32'(e.ready));
      check_output("avail",  32'(bus_if.InPortAvail),    32'(e.avail));
      check_output("ovf",    32'(bus_if.InPortOverflow), 32'(e.ovf));
    end
  end

  // Reference model: a plain queue of words plus a sticky flag.
  task automatic model_step(input logic v, input logic [31:0] d, input logic rd,
                            input logic sclr, input logic clr);
    int  sz;
    bit  was_full;
    exp_t e;
    if (clr) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      was_full = (model_q.size() == DEPTH);
      if (rd && model_q.size() > 0) void'(model_q.pop_front());
      if (sclr) model_ovf = 1'b0;
      if (v) begin
        if (was_full) model_ovf = 1'b1;
        else          model_q.push_back(d);
      end
    end
    sz       = model_q.size();
    e.cyc    = cyc_count + 1;
    e.bus    = (sz > 0) ? model_q[0] : 32'h0;
    e.status = 32'(sz)
             + ((sz == 0)     ? 32'h0001_0000 : 32'h0)
             + ((sz == DEPTH) ? 32'h0002_0000 : 32'h0)
             + (model_ovf     ? 32'h0004_0000 : 32'h0);
    e.ready  = (sz != DEPTH);
    e.avail  = (sz != 0);
    e.ovf    = model_ovf;
    exp_q.push_back(e);
  endtask

  // Drives one cycle of inputs, records the prediction, then steps past
  // the edge so the caller can sample settled outputs.
  task automatic apply_stimulus(input logic v, input logic [31:0] d,
                                input logic rd, input logic sclr,
                                input logic clr);
    bus_if.InPortValid = v;
    bus_if.InPortData  = d;
    bus_if.InPortRead  = rd;
    bus_if.InStatusClr = sclr;
    clear              = clr;
    model_step(v, d, rd, sclr, clr);
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_word();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned v_pct;
    int unsigned r_pct;

    // Reset held two cycles with a word offered: nothing may be stored.
    apply_stimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    check_output("reset_status", bus_if.BusMuxIn_InStatus, 32'h0001_0000);
    check_output("reset_bus",    bus_if.BusMuxIn_InPort,   32'h0);
    idle();

    // Single word in and out.
    push_word(32'h0000_00A5);
    check_output("single_bus", bus_if.BusMuxIn_InPort, 32'h0000_00A5);
    pop_word();
    check_output("single_empty", bus_if.BusMuxIn_InStatus, 32'h0001_0000);

    // Fill past capacity, clear the flag, then drain in order.
    for (int i = 1; i <= 9; i++) push_word(32'(i));
    check_output("fill_status", bus_if.BusMuxIn_InStatus, 32'h0006_0008);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_output("statusclr", bus_if.BusMuxIn_InStatus, 32'h0002_0008);
    for (int i = 1; i <= 8; i++) begin
      check_output("drain_order", bus_if.BusMuxIn_InPort, 32'(i));
      pop_word();
    end

    // Pointer wrap with bursts of five and six.
    for (int i = 0; i < 5; i++) push_word(32'h100 + 32'(i));
    for (int i = 0; i < 5; i++) pop_word();
    for (int i = 0; i < 6; i++) push_word(32'h200 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      check_output("wrap_order", bus_if.BusMuxIn_InPort, 32'h200 + 32'(i));
      pop_word();
    end

    // Push and pop together at count 3.
    for (int i = 0; i < 3; i++) push_word(32'h300 + 32'(i));
    apply_stimulus(1'b1, 32'h303, 1'b1, 1'b0, 1'b0);
    check_output("pushpop_mid", bus_if.BusMuxIn_InStatus, 32'h0000_0003);
    check_output("pushpop_head", bus_if.BusMuxIn_InPort, 32'h301);
    for (int i = 0; i < 3; i++) pop_word();

    // Push and pop together while empty: only the push lands.
    apply_stimulus(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    check_output("pushpop_empty", bus_if.BusMuxIn_InStatus, 32'h0000_0001);

    // Push and pop together while full: pop lands, push dropped.
    for (int i = 1; i < DEPTH; i++) push_word(32'h400 + 32'(i));
    apply_stimulus(1'b1, 32'h4FF, 1'b1, 1'b0, 1'b0);
    check_output("pushpop_full", bus_if.BusMuxIn_InStatus, 32'h0004_0007);

    // Refill, then drop a word while clearing the flag: set wins.
    push_word(32'h500);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h501, 1'b0, 1'b1, 1'b0);
    check_output("set_beats_clr", 32'(bus_if.InPortOverflow), 32'h1);

    // Clear in the middle of traffic, then a fresh word reads back.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) push_word(32'h600 + 32'(i));
    apply_stimulus(1'b1, 32'h6FF, 1'b1, 1'b0, 1'b1);
    check_output("clear_mid", bus_if.BusMuxIn_InStatus, 32'h0001_0000);
    push_word(32'hDEAD_BEEF);
    check_output("after_clear", bus_if.BusMuxIn_InPort, 32'hDEAD_BEEF);

    // Randomized traffic with phases that lean towards filling or draining.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        v_pct = $urandom_range(20, 90);
        r_pct = $urandom_range(20, 90);
      end
      apply_stimulus($urandom_range(0, 99) < v_pct, $urandom,
                     $urandom_range(0, 99) < r_pct,
                     $urandom_range(0, 99) < 8,
                     $urandom_range(0, 199) < 2);
    end

    idle();
    idle();
    @(negedge clock);
    #1;
    check_output("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
